// File: rtl/axi_wr_rd_test_master_if.sv
// AXI4 bus bundle shared by masters and slaves; Master/Slave modports give each
// side its own direction view of the five channels.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_USER_WIDTH = 64
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_wr_rd_test_master.sv
// One-shot AXI4 write-then-readback checker reporting done/pass/error.
// Define AXI_WR_RD_TEST_MASTER_TIMEOUT_EN to add a watchdog and the timeout_o port.
module axi_wr_rd_test_master #(
  parameter int unsigned AXI_ID_WIDTH   = 5,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_USER_WIDTH = 64,
  parameter logic [63:0] ADDRESS        = 64'h9000_0004,
  parameter logic [63:0] DATA           = 64'hABCD,
  parameter int unsigned TXN_ID         = 0,
  parameter int unsigned START_DELAY    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  AXI_BUS.Master axi_master_port,
  output logic   done_o,
  output logic   pass_o,
`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
  output logic   timeout_o,
`endif
  output logic   error_o
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_C = AXI_ADDR_WIDTH'(ADDRESS);
  localparam logic [AXI_DATA_WIDTH-1:0] DATA_C = AXI_DATA_WIDTH'(DATA);
  localparam logic [AXI_ID_WIDTH-1:0]   ID_C   = AXI_ID_WIDTH'(TXN_ID);
  localparam logic [2:0]                SIZE_C = 3'($clog2(STRB_W));
  localparam int unsigned               DLY_W  = $clog2(START_DELAY + 2);
  localparam logic [DLY_W-1:0]          DLY_LAST = DLY_W'(START_DELAY);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, DONE} state_t;

  state_t             state;
  logic [DLY_W-1:0]   dly_cnt;
  logic               aw_valid, w_valid, aw_done, w_done;
  logic               b_ready, ar_valid, r_ready;
  logic               done, pass, error;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_complete, b_bad, r_bad;

  assign aw_hs       = aw_valid & axi_master_port.aw_ready;
  assign w_hs        = w_valid  & axi_master_port.w_ready;
  assign b_hs        = b_ready  & axi_master_port.b_valid;
  assign ar_hs       = ar_valid & axi_master_port.ar_ready;
  assign r_hs        = r_ready  & axi_master_port.r_valid;
  assign wr_complete = (aw_done | aw_hs) & (w_done | w_hs);
  assign b_bad = (axi_master_port.b_resp != 2'b00) | (axi_master_port.b_id != ID_C);
  assign r_bad = (axi_master_port.r_resp != 2'b00) | !axi_master_port.r_last |
                 (axi_master_port.r_id != ID_C) | (axi_master_port.r_data != DATA_C);

`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
  localparam int unsigned    WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout, active, leave;

  always_comb begin
    leave  = 1'b0;
    active = 1'b1;
    case (state)
      WRITE:   leave = wr_complete;
      WAIT_B:  leave = b_hs;
      READ:    leave = ar_hs;
      WAIT_R:  leave = r_hs;
      default: active = 1'b0;
    endcase
  end

  assign timeout_o = timeout;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      b_ready  <= 1'b0;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      error    <= 1'b0;
`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
      wd_cnt   <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (dly_cnt == DLY_LAST) begin
            state    <= WRITE;
            aw_valid <= 1'b1;
            w_valid  <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        // AW and W complete independently; the done flags remember which already fired.
        WRITE: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs) begin
            w_valid <= 1'b0;
            w_done  <= 1'b1;
          end
          if (wr_complete) begin
            state   <= WAIT_B;
            b_ready <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WAIT_B: begin
          if (b_hs) begin
            b_ready  <= 1'b0;
            ar_valid <= 1'b1;
            state    <= READ;
            if (b_bad) error <= 1'b1;
          end
        end
        READ: begin
          if (ar_hs) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (r_hs) begin
            r_ready <= 1'b0;
            done    <= 1'b1;
            pass    <= !(error | r_bad);
            state   <= DONE;
            if (r_bad) error <= 1'b1;
          end
        end
        default: ;
      endcase
`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
      wd_cnt <= (!active || leave) ? '0 : wd_cnt + WD_W'(1);
      // Expiry overrides whatever the state machine scheduled this cycle.
      if (active && wd_cnt == WD_LAST) begin
        state    <= DONE;
        aw_valid <= 1'b0;
        w_valid  <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        b_ready  <= 1'b0;
        ar_valid <= 1'b0;
        r_ready  <= 1'b0;
        done     <= 1'b1;
        pass     <= 1'b0;
        error    <= 1'b1;
        timeout  <= 1'b1;
      end
`endif
    end
  end

  assign done_o  = done;
  assign pass_o  = pass;
  assign error_o = error;

  assign axi_master_port.aw_id     = ID_C;
  assign axi_master_port.aw_addr   = ADDR_C;
  assign axi_master_port.aw_len    = 8'd0;
  assign axi_master_port.aw_size   = SIZE_C;
  assign axi_master_port.aw_burst  = 2'b01;
  assign axi_master_port.aw_lock   = 1'b0;
  assign axi_master_port.aw_cache  = 4'd0;
  assign axi_master_port.aw_prot   = 3'd0;
  assign axi_master_port.aw_qos    = 4'd0;
  assign axi_master_port.aw_region = 4'd0;
  assign axi_master_port.aw_atop   = 6'd0;
  assign axi_master_port.aw_user   = '0;
  assign axi_master_port.aw_valid  = aw_valid;

  assign axi_master_port.w_data    = DATA_C;
  assign axi_master_port.w_strb    = '1;
  assign axi_master_port.w_last    = 1'b1;
  assign axi_master_port.w_user    = '0;
  assign axi_master_port.w_valid   = w_valid;

  assign axi_master_port.b_ready   = b_ready;

  assign axi_master_port.ar_id     = ID_C;
  assign axi_master_port.ar_addr   = ADDR_C;
  assign axi_master_port.ar_len    = 8'd0;
  assign axi_master_port.ar_size   = SIZE_C;
  assign axi_master_port.ar_burst  = 2'b01;
  assign axi_master_port.ar_lock   = 1'b0;
  assign axi_master_port.ar_cache  = 4'd0;
  assign axi_master_port.ar_prot   = 3'd0;
  assign axi_master_port.ar_qos    = 4'd0;
  assign axi_master_port.ar_region = 4'd0;
  assign axi_master_port.ar_user   = '0;
  assign axi_master_port.ar_valid  = ar_valid;

  assign axi_master_port.r_ready   = r_ready;

endmodule

// File: tb/tb_axi_wr_rd_test_master.sv
// Directed bench for axi_wr_rd_test_master against a small configurable AXI slave
// (ready delays, error responses, corrupted read data, stalled AR).
module tb_axi_wr_rd_test_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done, pass, error;
`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
  logic timeout;
`endif

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(5),
            .AXI_USER_WIDTH(64)) bus ();

  axi_wr_rd_test_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .axi_master_port (bus),
    .done_o          (done),
    .pass_o          (pass),
`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
    .timeout_o       (timeout),
`endif
    .error_o         (error)
  );

  int vectors = 0;
  int miscompares = 0;

  int          aw_delay = 0, b_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic        r_bad_data = 1'b0, ar_block = 1'b0;
  int          aw_count = 0, w_count = 0, ar_count = 0;
  logic [63:0] mem = '0;

  // Slave drives its side on the falling edge, reacting to what the master showed.
  initial begin
    int aw_wait, b_wait;
    aw_wait = 0;
    b_wait  = 0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.ar_ready = 1'b0;
    bus.b_valid = 1'b0; bus.b_id = '0; bus.b_resp = 2'b00; bus.b_user = '0;
    bus.r_valid = 1'b0; bus.r_id = '0; bus.r_resp = 2'b00; bus.r_last = 1'b0;
    bus.r_data = '0; bus.r_user = '0;
    forever begin
      @(negedge clk);
      if (!bus.aw_valid) begin
        aw_wait = 0;
        bus.aw_ready = 1'b0;
      end else begin
        bus.aw_ready = (aw_wait >= aw_delay);
        if (!bus.aw_ready) aw_wait++;
      end
      bus.w_ready = bus.w_valid;
      if (!bus.b_ready) begin
        b_wait = 0;
        bus.b_valid = 1'b0;
      end else begin
        bus.b_valid = (b_wait >= b_delay);
        if (!bus.b_valid) b_wait++;
      end
      bus.b_resp   = b_resp_cfg;
      bus.ar_ready = bus.ar_valid && !ar_block;
      bus.r_valid  = bus.r_ready;
      bus.r_last   = 1'b1;
      bus.r_data   = r_bad_data ? 64'h1234 : mem;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.aw_valid && bus.aw_ready) aw_count++;
      if (bus.w_valid && bus.w_ready) begin
        w_count++;
        mem = bus.w_data;
      end
      if (bus.ar_valid && bus.ar_ready) ar_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] aborting");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int awd, input int bd, input logic [1:0] resp,
                                input logic rbad, input logic arb);
    rst_n      = 1'b0;
    aw_delay   = awd;
    b_delay    = bd;
    b_resp_cfg = resp;
    r_bad_data = rbad;
    ar_block   = arb;
    aw_count = 0; w_count = 0; ar_count = 0;
    mem = '0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {done, pass, error, bus.aw_valid, bus.w_valid,
                                   bus.ar_valid, bus.b_ready, bus.r_ready}, 64'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_aw(output int cyc);
    cyc = 0;
    while (!bus.aw_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_ar(input string tag);
    int g = 0;
    while (!bus.ar_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_output(tag, bus.ar_valid, 1);
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 300) begin
      @(negedge clk);
      g++;
    end
    check_output(tag, done, 1);
  endtask

  initial begin
    int cyc, n_aw, n_w, unstable, g;

    $display("[TB] scenario 1: zero-wait slave");
    apply_stimulus(0, 0, 2'b00, 1'b0, 1'b0);
    wait_aw(cyc);
    check_output("first_aw_latency", cyc, 11);
    check_output("w_valid_with_aw", bus.w_valid, 1);
    check_output("aw_addr", bus.aw_addr, 64'h9000_0004);
    check_output("aw_len_size_burst", {bus.aw_len, 1'b0, bus.aw_size, 2'b00, bus.aw_burst},
                 {8'd0, 1'b0, 3'd3, 2'b00, 2'b01});
    check_output("aw_id", bus.aw_id, 0);
    check_output("w_data", bus.w_data, 64'hABCD);
    check_output("w_strb_last", {bus.w_strb, bus.w_last}, {8'hFF, 1'b1});
    wait_done("s1_done");
    check_output("s1_pass_error", {pass, error}, 2'b10);
    repeat (5) @(negedge clk);
    check_output("s1_counts", {aw_count[7:0], w_count[7:0], ar_count[7:0]}, 24'h010101);
    check_output("s1_mem", mem, 64'hABCD);
    check_output("s1_idle_in_done", {bus.aw_valid, bus.w_valid, bus.ar_valid,
                                     bus.b_ready, bus.r_ready, done}, 6'b000001);

    $display("[TB] scenario 2: aw_ready delayed 3 cycles");
    apply_stimulus(3, 0, 2'b00, 1'b0, 1'b0);
    wait_aw(cyc);
    n_aw = 0; n_w = 0; unstable = 0; g = 0;
    while ((bus.aw_valid || bus.w_valid) && g < 20) begin
      if (bus.aw_valid) begin
        n_aw++;
        if (bus.aw_addr !== 64'h9000_0004 || bus.aw_len !== 8'd0 || bus.aw_size !== 3'd3)
          unstable++;
      end
      if (bus.w_valid) n_w++;
      @(negedge clk);
      g++;
    end
    check_output("s2_aw_valid_cycles", n_aw, 4);
    check_output("s2_w_valid_cycles", n_w, 1);
    check_output("s2_aw_fields_stable", unstable, 0);
    wait_done("s2_done");
    check_output("s2_pass_error", {pass, error}, 2'b10);
    check_output("s2_single_write", {aw_count[7:0], w_count[7:0]}, 16'h0101);

    $display("[TB] scenario 3: SLVERR write response");
    apply_stimulus(0, 0, 2'b10, 1'b0, 1'b0);
    wait_ar("s3_read_started");
    check_output("s3_error_after_b", error, 1);
    wait_done("s3_done");
    check_output("s3_pass_error", {pass, error}, 2'b01);
    check_output("s3_read_count", ar_count, 1);

    $display("[TB] scenario 4: corrupted read data");
    apply_stimulus(0, 0, 2'b00, 1'b1, 1'b0);
    wait_ar("s4_read_started");
    check_output("s4_error_before_r", error, 0);
    wait_done("s4_done");
    check_output("s4_pass_error", {pass, error}, 2'b01);
    check_output("s4_mem_written", mem, 64'hABCD);

    $display("[TB] scenario 5: reset pulse in WAIT_B");
    apply_stimulus(0, 5, 2'b00, 1'b0, 1'b0);
    g = 0;
    while (!bus.b_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check_output("s5_in_wait_b", bus.b_ready, 1);
    rst_n = 1'b0;
    #1;
    check_output("s5_async_reset", {done, pass, error, bus.aw_valid, bus.w_valid,
                                    bus.ar_valid, bus.b_ready, bus.r_ready}, 64'd0);
    b_delay = 0;
    aw_count = 0; w_count = 0; ar_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_aw(cyc);
    check_output("s5_restart_latency", cyc, 11);
    wait_done("s5_done");
    check_output("s5_pass_error", {pass, error}, 2'b10);
    check_output("s5_counts", {aw_count[7:0], w_count[7:0], ar_count[7:0]}, 24'h010101);

`ifdef AXI_WR_RD_TEST_MASTER_TIMEOUT_EN
    $display("[TB] scenario 6: ar_ready never asserted");
    apply_stimulus(0, 0, 2'b00, 1'b0, 1'b1);
    wait_ar("s6_read_started");
    check_output("s6_no_timeout_yet", timeout, 0);
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_output("s6_within_17", (g <= 17), 1);
    check_output("s6_flags", {timeout, error, done, pass, bus.ar_valid}, 5'b11100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
